// File: rtl/s27_query_seq.sv
// Oracle query sequencer for the s27 core: drives a stored vector sequence onto G0-G3,
// samples G17 once per vector and returns the packed trace as a response.
module s27_query_seq #(
   parameter int SEQ_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic                 q_valid,
   output logic                 q_ready,
   input  logic [4*SEQ_LEN-1:0] q_vec,
   input  logic [LEN_W-1:0]     q_len,
   input  logic                 q_init,
   output logic [3:0]           dut_g,
   output logic                 dut_rn,
   input  logic                 dut_g17,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [SEQ_LEN-1:0]   r_resp,
   output logic [LEN_W-1:0]     r_len,
   output logic [CNT_W-1:0]     q_count
);

   localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

   typedef enum logic [1:0] {IDLE, DRST, APPLY, DONE} state_t;

   state_t             state, state_n;
   logic [3:0]         vec_q [SEQ_LEN];
   logic [LEN_W-1:0]   len_q, len_n, eff_len;
   logic [IDX_W-1:0]   idx, idx_n, nidx;
   logic               last;
   logic               vec_ld;
   logic               q_ready_n, r_valid_n, dut_rn_n;
   logic [3:0]         dut_g_n;
   logic [SEQ_LEN-1:0] r_resp_n;
   logic [LEN_W-1:0]   r_len_n;
   logic [CNT_W-1:0]   q_count_n;

   assign eff_len = (q_len > LEN_W'(SEQ_LEN)) ? LEN_W'(SEQ_LEN) : q_len;
   assign nidx    = idx + IDX_W'(1);
   assign last    = (LEN_W'(idx) + LEN_W'(1)) == len_q;

   always_comb begin
      state_n   = state;
      q_ready_n = q_ready;
      r_valid_n = r_valid;
      r_resp_n  = r_resp;
      r_len_n   = r_len;
      dut_g_n   = dut_g;
      dut_rn_n  = dut_rn;
      q_count_n = q_count;
      idx_n     = idx;
      len_n     = len_q;
      vec_ld    = 1'b0;
      case (state)
         IDLE: begin
            q_ready_n = 1'b1;
            dut_rn_n  = 1'b1;
            dut_g_n   = 4'd0;
            if (q_valid && q_ready) begin
               vec_ld    = 1'b1;
               len_n     = eff_len;
               r_len_n   = eff_len;
               r_resp_n  = '0;
               idx_n     = '0;
               q_ready_n = 1'b0;
               if (q_init) begin
                  state_n  = DRST;
                  dut_rn_n = 1'b0;
               end else if (eff_len != '0) begin
                  state_n = APPLY;
                  dut_g_n = q_vec[3:0];
               end else begin
                  state_n   = DONE;
                  r_valid_n = 1'b1;
               end
            end
         end
         DRST: begin
            dut_rn_n = 1'b1;
            if (len_q != '0) begin
               state_n = APPLY;
               dut_g_n = vec_q[0];
            end else begin
               state_n   = DONE;
               r_valid_n = 1'b1;
            end
         end
         APPLY: begin
            // G17 for vector idx is settled by the end of the cycle it is driven
            r_resp_n[idx] = dut_g17;
            if (last) begin
               state_n   = DONE;
               dut_g_n   = 4'd0;
               r_valid_n = 1'b1;
            end else begin
               idx_n   = nidx;
               dut_g_n = vec_q[nidx];
            end
         end
         DONE: begin
            if (r_ready) begin
               state_n   = IDLE;
               r_valid_n = 1'b0;
               q_ready_n = 1'b1;
               q_count_n = q_count + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state   <= IDLE;
         q_ready <= 1'b0;
         r_valid <= 1'b0;
         r_resp  <= '0;
         r_len   <= '0;
         dut_g   <= 4'd0;
         dut_rn  <= 1'b0;
         q_count <= '0;
         idx     <= '0;
         len_q   <= '0;
      end else begin
         state   <= state_n;
         q_ready <= q_ready_n;
         r_valid <= r_valid_n;
         r_resp  <= r_resp_n;
         r_len   <= r_len_n;
         dut_g   <= dut_g_n;
         dut_rn  <= dut_rn_n;
         q_count <= q_count_n;
         idx     <= idx_n;
         len_q   <= len_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (vec_ld) begin
         for (int i = 0; i < SEQ_LEN; i++) vec_q[i] <= q_vec[4*i +: 4];
      end
   end

endmodule

// File: doc/s27_query_seq.md
Name: s27_query_seq

Overview:
- Query sequencer that sits in front of and behind the s27 core (G0–G3 in, G17 out).
- Accepts a query from the attack host: a sequence of up to SEQ_LEN 4-bit input vectors, plus an optional core-reset request.
- Drives the vectors onto G0–G3 one per clock and samples G17 each clock.
- Returns the packed output trace as the oracle response.

Parameters:
- SEQ_LEN, 8, maximum vectors per query.
- LEN_W, 4, width of the length fields; must hold SEQ_LEN.
- CNT_W, 16, width of the query counter.

Ports:
- CLK  input  1  single clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- q_valid  input  1  query offered.
- q_ready  output  1  sequencer can accept a query.
- q_vec  input  4*SEQ_LEN  vector i = q_vec[4i+3:4i]; bit0=G0 … bit3=G3.
- q_len  input  LEN_W  number of vectors to apply.
- q_init  input  1  reset the s27 core before applying vectors.
- dut_g  output  4  drives {G3,G2,G1,G0} of the core.
- dut_rn  output  1  drives the RN pin of the core flops.
- dut_g17  input  1  G17 from the core.
- r_valid  output  1  response available.
- r_ready  input  1  host accepts response.
- r_resp  output  SEQ_LEN  bit i = G17 sampled during vector i.
- r_len  output  LEN_W  number of valid bits in r_resp.
- q_count  output  CNT_W  completed queries, wraps.

Behaviour:
- Reset values (RN low, async):
  - State IDLE; q_ready=0, r_valid=0.
  - r_resp=0, r_len=0, dut_g=0, dut_rn=0 (core held in reset), q_count=0.
- First rising edge after RN deasserts: dut_rn←1, q_ready←1.
- All outputs are registered; no combinational path from q_* or dut_g17 to any output.
- States: IDLE, DRST, APPLY, DONE.
- IDLE:
  - q_ready=1, dut_g=0, dut_rn=1.
  - On q_valid&q_ready: latch q_vec and effective length L.
  - L = min(q_len, SEQ_LEN).
  - Clear the response shift register and set idx=0.
  - Next state: DRST if q_init, else APPLY if L>0, else DONE.
- Zero-length query: goes to DONE with r_resp=0 and r_len=0; q_count still increments.
- DRST:
  - Exactly one cycle; dut_rn=0, dut_g=0.
  - The core flops clear (G5=G6=G7=0).
  - Then APPLY if L>0, else DONE.
- APPLY:
  - Cycle k (k=0..L-1): dut_g = vector k.
  - On the closing edge, capture dut_g17 into r_resp[k]; the core flops advance on the same edge.
  - After k=L-1: go to DONE and set dut_g←0.
  - Latency from acceptance to r_valid = L+1 cycles, or L+2 with q_init.
- DONE:
  - r_valid=1; r_resp and r_len stable; unused r_resp bits [SEQ_LEN-1:L] are 0.
  - On r_valid&r_ready: r_valid←0, q_count←q_count+1 (wraps 2^CNT_W-1→0), return to IDLE.
  - q_ready returns to 1 the cycle after the handshake, so queries are back-to-back with a 1-cycle bubble.
- q_ready=0 in DRST, APPLY and DONE; q_valid there is ignored and the host must hold it.
- Core state persists across queries unless q_init=1. This is intentional: sequential oracle queries continue from the prior state.
- RN asserted mid-query:
  - Everything returns to reset values immediately; dut_rn=0 clears the core.
  - The in-flight query is dropped and no response is produced.
- r_ready held high before DONE has no effect.

Test Plan:
- Reset release: RN low 3 cycles then high.
  - During reset: dut_rn=0, q_ready=0, r_valid=0, dut_g=0, q_count=0.
  - One edge after release: dut_rn=1 and q_ready=1.
- Query q_init=1, q_len=4, q_vec=0x0000_0000:
  - One DRST cycle with dut_rn=0, then 4 APPLY cycles.
  - r_resp=8'h0F, r_len=4, r_valid 6 cycles after acceptance, q_count=1.
- Query q_init=1, q_len=2, q_vec=0x0000_0088 (G3=1 both cycles):
  - r_resp=8'h00, r_len=2 (core G11=1 both cycles).
- Follow-up without q_init: q_len=1, q_vec=0x0:
  - Core state retained (G6=1), so r_resp=8'h00.
  - Contrast: the same query with q_init=1 returns r_resp=8'h01.
- Boundary lengths:
  - q_len=0: DONE after 1 cycle, r_len=0, r_resp=0.
  - q_len=12 with SEQ_LEN=8: 8 vectors applied, r_len=8.
  - r_ready held low 10 cycles in DONE: response held stable and q_ready stays 0.
- RN pulsed low during APPLY k=2:
  - All outputs return to reset values immediately; no r_valid.
  - q_count unchanged; the next query runs correctly.
